// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x-oversampling UART receive front end producing one
// FIFO write strobe per character with MC68681-style parity/framing/break status.
module uart_rx_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_x16_en,
    input  logic       rxd,
    input  logic       rx_enable,
    input  logic [1:0] bits_per_char,
    input  logic       par_en,
    input  logic       par_odd,
    output logic       wr,
    output logic [7:0] d_out,
    output logic       par_err,
    output logic       frame_err,
    output logic       rcv_break,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic                   perr;
    logic                   rxd_s;
    logic [2:0]             last_bit;
    logic                   brk_now;

    assign rxd_s    = sync[SYNC_STAGES-1];
    assign last_bit = {1'b0, bits_per_char} + 3'd4;
    assign brk_now  = (shreg == 8'h00) && !par_bit && !rxd_s;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sync <= '1;
        else
            sync <= {sync[SYNC_STAGES-2:0], rxd};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            par_bit   <= 1'b0;
            perr      <= 1'b0;
            wr        <= 1'b0;
            d_out     <= 8'h00;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            rcv_break <= 1'b0;
        end else begin
            wr <= 1'b0;
            if (!rx_enable) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (baud_x16_en) begin
                cnt <= cnt + 4'd1;
                case (state)
                    IDLE: if (!rxd_s) begin
                        state   <= START;
                        cnt     <= 4'd0;
                        bit_idx <= 3'd0;
                        shreg   <= 8'h00;
                        par_bit <= 1'b0;
                        perr    <= 1'b0;
                    end
                    // Mid start bit is reached as the counter steps onto 7.
                    START: if (cnt == 4'd6) begin
                        cnt   <= 4'd0;
                        state <= rxd_s ? IDLE : DATA;
                    end
                    DATA: if (cnt == 4'd15) begin
                        shreg[bit_idx] <= rxd_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == last_bit)
                            state <= par_en ? PARITY : STOP;
                    end
                    PARITY: if (cnt == 4'd15) begin
                        par_bit <= rxd_s;
                        perr    <= rxd_s != (^shreg ^ par_odd);
                        state   <= STOP;
                    end
                    STOP: if (cnt == 4'd15) begin
                        wr        <= 1'b1;
                        d_out     <= shreg;
                        frame_err <= !rxd_s;
                        par_err   <= perr && !brk_now;
                        rcv_break <= brk_now;
                        state     <= rxd_s ? IDLE : BREAK_WAIT;
                    end
                    BREAK_WAIT: if (rxd_s) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: randomized serial stimulus with a queue-based
// scoreboard; a negedge monitor pops one expectation per write strobe.
module tb_uart_rx_deserializer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_x16_en = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_enable = 1'b1;
    logic [1:0] bits_per_char = 2'b11;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       wr;
    logic [7:0] d_out;
    logic       par_err, frame_err, rcv_break, busy;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
        int         at;
    } exp_t;

    exp_t sbq[$];
    exp_t last;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   tick_rand = 1'b0;

    uart_rx_deserializer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .baud_x16_en(baud_x16_en), .rxd(rxd),
        .rx_enable(rx_enable), .bits_per_char(bits_per_char), .par_en(par_en),
        .par_odd(par_odd), .wr(wr), .d_out(d_out), .par_err(par_err),
        .frame_err(frame_err), .rcv_break(rcv_break), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1 baud_x16_en = tick_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_ticks(input int k);
        repeat (k) begin
            do @(posedge clk); while (!baud_x16_en);
        end
        #1;
    endtask

    // Expected status is derived from the line-level character content.
    task automatic send_char(input logic [7:0] data, input int n, input bit pe, input bit odd,
                             input bit bad_par, input bit stop, input int gap);
        logic [7:0] d;
        logic       pb;
        exp_t       e;
        d  = data & 8'((1 << n) - 1);
        pb = pe ? (1'(($countones(d) + int'(odd)) % 2) ^ bad_par) : 1'b0;
        e.d   = d;
        e.brk = (d == 8'h00) && !pb && !stop;
        e.fe  = !stop;
        e.pe  = pe && bad_par && !e.brk;
        e.at  = tick_rand ? -1 : cyc + 3 + 7 + 16 * (n + int'(pe) + 1);
        bits_per_char = 2'(n - 5);
        par_en  = pe;
        par_odd = odd;
        sbq.push_back(e);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < n; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
        if (pe) begin
            rxd = pb;
            wait_ticks(16);
        end
        rxd = stop;
        wait_ticks(16);
        rxd = 1'b1;
        wait_ticks(gap);
    endtask

    task automatic partial_char(input logic [7:0] d, input int upto);
        bits_per_char = 2'b11;
        par_en = 1'b0;
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < upto; i++) begin
            rxd = d[i];
            wait_ticks(16);
        end
        rxd = d[upto];
        wait_ticks(8);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr) begin
                if (sbq.size() == 0) begin
                    check("unexpected_wr", 32'(wr), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    last = e;
                    check("d_out", 32'(d_out), 32'(e.d));
                    check("par_err", 32'(par_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("rcv_break", 32'(rcv_break), 32'(e.brk));
                    if (e.at >= 0) check("wr_time", 32'(cyc), 32'(e.at));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        last = '{8'h00, 1'b0, 1'b0, 1'b0, -1};
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, wr, par_err, frame_err, rcv_break, busy, 1'b0} | 32'(d_out), 32'd0);
        reset_n = 1'b1;
        wait_ticks(5);

        send_char(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 20);
        send_char(8'h41, 7, 1'b1, 1'b0, 1'b0, 1'b1, 20);
        send_char(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 20);

        rxd = 1'b0;
        wait_ticks(4);
        rxd = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_ticks(16);
        check("glitch_busy_low", 32'(busy), 32'd0);
        wait_ticks(10);

        send_char(8'h15, 5, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        send_char(8'h0A, 5, 1'b0, 1'b0, 1'b0, 1'b1, 20);

        bits_per_char = 2'b11;
        par_en = 1'b1;
        par_odd = 1'b0;
        sbq.push_back('{8'h00, 1'b0, 1'b1, 1'b1, cyc + 3 + 7 + 16 * 10});
        rxd = 1'b0;
        wait_ticks(16 * 30);
        check("break_wait_busy", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("break_release_idle", 32'(busy), 32'd0);
        wait_ticks(20);

        partial_char(8'h5A, 3);
        rx_enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable_idle", 32'(busy), 32'd0);
        check("disable_hold_status", {20'd0, d_out, par_err, frame_err, rcv_break, 1'b0},
              {20'd0, last.d, last.pe, last.fe, last.brk, 1'b0});
        rxd = 1'b1;
        wait_ticks(4);
        rx_enable = 1'b1;
        wait_ticks(40);
        send_char(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 20);

        partial_char(8'hA7, 5);
        #2 reset_n = 1'b0;
        rxd = 1'b1;
        #1;
        check("midchar_reset_outputs", {26'd0, wr, par_err, frame_err, rcv_break, busy, 1'b0} | 32'(d_out), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_ticks(40);
        send_char(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 20);

        for (int i = 0; i < 36; i++) begin
            logic [7:0] d;
            if (i == 24) tick_rand = 1'b1;
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            send_char(d, $urandom_range(5, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0, $urandom_range(4, 20));
        end
        tick_rand = 1'b0;
        wait_ticks(20);
        check("all_wr_seen", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive front end of one DUART channel: oversamples the serial RxD line at 16x baud and recovers start, data, parity and stop bits.
- Each recovered character is presented with a one-cycle write strobe that feeds directly into the channel's 4-deep receive FIFO (wr/d_in).
- Per-character parity error, framing error and received-break status are produced alongside the data, matching MC68681 status register semantics.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rxd metastability synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- baud_x16_en  input  1  single-cycle tick at 16x the baud rate. All bit timing advances only on ticks.
- rxd  input  1  asynchronous serial input. Idle (mark) = 1.
- rx_enable  input  1  receiver enable (CR RxEN). 0 forces IDLE.
- bits_per_char  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- par_en  input  1  1 = parity bit present after the data bits.
- par_odd  input  1  1 = odd parity, 0 = even parity. Ignored when par_en=0.
- wr  output  1  one-clk pulse, character ready. Connects to the FIFO wr input.
- d_out  output  8  received character, LSB first on the line. Unused upper bits = 0.
- par_err  output  1  parity error for the current d_out. Valid with wr; held until the next wr.
- frame_err  output  1  stop bit sampled as 0. Valid with wr; held until the next wr.
- rcv_break  output  1  break character flag. Valid with wr; held until the next wr.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, tick counter=0, shift register=0, synchronizer stages=1. wr=0, d_out=0x00, par_err=0, frame_err=0, rcv_break=0, busy=0.
- rxd passes through a SYNC_STAGES-deep synchronizer before any use. The synchronizer samples on every clk, not only on ticks.
- The tick counter is 4 bits wide and increments on baud_x16_en only. It wraps 15->0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: on a tick with synchronized rxd=0 and rx_enable=1, go to START with counter=0.
- START: at counter=7 (mid-bit), if rxd=1, the start was false: return to IDLE with no wr. Otherwise reset counter to 0 and go to DATA with bit index=0.
- DATA: sample at each counter=15 wrap, i.e. 16 ticks after the previous sample. Shift the sample into bit[index]. After bit (N-1) is sampled, go to PARITY if par_en=1, else STOP.
- PARITY: sample once. Expected parity bit = XOR of the N data bits, XOR par_odd. par_err = (sample != expected).
- STOP: sample once.
  - d_out is written with the data bits, upper (8-N) bits zeroed, and wr pulses high for exactly the one clk cycle following the stop sampling tick.
  - frame_err = (stop sample == 0).
  - rcv_break = 1 when the data bits, the parity bit (if present) and the stop bit are all 0. In that case d_out=0x00, frame_err=1 and par_err=0 (parity check suppressed).
  - Next state: IDLE when the stop sample = 1, so a new start can be detected from the next tick (half-stop-bit resynchronization). Otherwise BREAK_WAIT.
- BREAK_WAIT: no further wr. Go to IDLE on the first tick with synchronized rxd=1. A framing error without a break also passes through BREAK_WAIT, so a stuck-low line produces exactly one character.
- Timing for an unbroken character: the wr cycle follows the tick that lies 7 + 16*(N + par_en + 1) ticks after the start-detect tick.
- rx_enable=0 in any state: next clk state=IDLE, the partial character is discarded, no wr is issued, and the status outputs are unchanged.
- baud_x16_en held low freezes the FSM and the counter. wr never asserts without a preceding tick.
- reset_n asserted mid-character: immediate return to reset values. No wr is issued after release until a full new character is received.
- No back-pressure: the FIFO flags overrun itself, and this block never stalls.

Test Plan:
- baud_x16_en tied 1; 8N1 (bits_per_char=11, par_en=0); send 0xA5 -> single wr pulse 151 ticks after start detect; d_out=0xA5; par_err=0, frame_err=0, rcv_break=0.
- 7E1 (bits_per_char=10, par_en=1, par_odd=0); send 0x41 with correct parity bit 0, then 0x41 with parity bit 1 -> first: d_out=0x41, par_err=0; second: par_err=1. Both d_out upper bit = 0.
- 0.25-bit (4-tick) low glitch on rxd while IDLE -> return to IDLE; no wr; busy drops after the start-bit check.
- 5N1; send 0x15 with stop bit forced 0, then line high -> d_out=0x15, frame_err=1, rcv_break=0; next good char 0x0A -> frame_err=0.
- 8E1; hold rxd=0 for 30 bit times, then release -> exactly one wr with d_out=0x00, rcv_break=1, frame_err=1, par_err=0; the FSM remains in BREAK_WAIT until rxd=1, then goes to IDLE.
- Drop rx_enable at DATA bit 3, and separately pulse reset_n at DATA bit 5 -> no wr in either case; outputs reset (reset case); the following 0x3C character is received correctly.
